// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversample tick: synchronises rx, validates the
// start bit at mid-bit, centre-samples data LSB first, checks stop, flags errors.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_enb,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t               r_state,      w_state;
  logic [CNT_W-1:0]     r_sample_cnt, w_sample_cnt;
  logic [IDX_W-1:0]     r_bit_idx,    w_bit_idx;
  logic [DATA_BITS-1:0] r_shift,      w_shift;
  logic [DATA_BITS-1:0] r_data,       w_data;
  logic                 r_rdy,        w_rdy;
  logic                 r_frame_err,  w_frame_err;
  logic                 r_overrun,    w_overrun;
  logic                 r_busy,       w_busy;
  logic                 r_rx_meta;
  logic                 r_rx_s;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_sample_cnt <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_rdy        <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_sample_cnt <= w_sample_cnt;
      r_bit_idx    <= w_bit_idx;
      r_shift      <= w_shift;
      r_data       <= w_data;
      r_rdy        <= w_rdy;
      r_frame_err  <= w_frame_err;
      r_overrun    <= w_overrun;
      r_busy       <= w_busy;
    end
  end

  // Frame sequencing; the consumer clear is applied first so a same-cycle
  // completion or framing error wins over it.
  always_comb begin
    w_state      = r_state;
    w_sample_cnt = r_sample_cnt;
    w_bit_idx    = r_bit_idx;
    w_shift      = r_shift;
    w_data       = r_data;
    w_rdy        = r_rdy;
    w_frame_err  = r_frame_err;
    w_overrun    = r_overrun;

    if (rdy_clr) begin
      w_rdy       = 1'b0;
      w_frame_err = 1'b0;
      w_overrun   = 1'b0;
    end

    if (rx_enb) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            w_state      = S_START;
            w_sample_cnt = '0;
          end
        end
        S_START: begin
          if (r_sample_cnt == CNT_HALF) begin
            w_sample_cnt = '0;
            if (!r_rx_s) begin
              w_state   = S_DATA;
              w_bit_idx = '0;
            end else begin
              w_state = S_IDLE;
            end
          end else begin
            w_sample_cnt = r_sample_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (r_sample_cnt == CNT_LAST) begin
            w_shift      = {r_rx_s, r_shift[DATA_BITS-1:1]};
            w_sample_cnt = '0;
            if (r_bit_idx == IDX_LAST) begin
              w_state = S_STOP;
            end else begin
              w_bit_idx = r_bit_idx + IDX_W'(1);
            end
          end else begin
            w_sample_cnt = r_sample_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          // Leaving at mid-stop keeps the next start edge on its own tick grid.
          if (r_sample_cnt == CNT_LAST) begin
            if (r_rx_s) begin
              w_data = r_shift;
              w_rdy  = 1'b1;
              if (r_rdy && !rdy_clr) begin
                w_overrun = 1'b1;
              end
            end else begin
              w_frame_err = 1'b1;
            end
            w_state      = S_IDLE;
            w_sample_cnt = '0;
          end else begin
            w_sample_cnt = r_sample_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state      = S_IDLE;
          w_sample_cnt = '0;
        end
      endcase
    end

    w_busy = (w_state != S_IDLE);
  end

  assign data      = r_data;
  assign rdy       = r_rdy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: each frame pushes its expected outcome, a monitor
// pops and compares on every end of a busy period.
module tb_uart_rx;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned OS       = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rx_enb;
  logic       rdy_clr;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  typedef struct {
    int         ticks;
    logic       rdy;
    logic [7:0] data;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Bench-side reference of the output flags
  logic       m_rdy = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_fe = 1'b0;
  logic       m_ov = 1'b0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_enb    (rx_enb),
    .rdy_clr   (rdy_clr),
    .data      (data),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One oversample tick; optional consumer clear on the same clock.
  task automatic tick(input logic clr);
    repeat (TICK_DIV - 1) @(negedge clk);
    rx_enb  = 1'b1;
    rdy_clr = clr;
    @(negedge clk);
    rx_enb  = 1'b0;
    rdy_clr = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick(1'b0);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
    m_rdy = 1'b0;
    m_fe  = 1'b0;
    m_ov  = 1'b0;
    check("clr_rdy", 32'(rdy), 32'(m_rdy));
    check("clr_frame_err", 32'(frame_err), 32'(m_fe));
    check("clr_overrun", 32'(overrun), 32'(m_ov));
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic clr_done,
                            input int stall_bit);
    exp_t e;
    if (stop) begin
      m_ov   = clr_done ? 1'b0 : (m_rdy ? 1'b1 : m_ov);
      m_fe   = clr_done ? 1'b0 : m_fe;
      m_rdy  = 1'b1;
      m_data = b;
    end else begin
      m_fe  = 1'b1;
      m_rdy = clr_done ? 1'b0 : m_rdy;
      m_ov  = clr_done ? 1'b0 : m_ov;
    end
    e.ticks = 152;
    e.rdy   = m_rdy;
    e.data  = m_data;
    e.fe    = m_fe;
    e.ov    = m_ov;
    q.push_back(e);

    rx = 1'b0;
    ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == stall_bit) begin
        ticks(5);
        repeat (1000) @(negedge clk);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_rdy", 32'(rdy), 32'(m_rdy ^ 1'b1));
        ticks(OS - 5);
      end else begin
        ticks(OS);
      end
    end
    rx = stop;
    ticks(8);
    tick(clr_done);
    rx = 1'b1;
    ticks(7);
  endtask

  // Monitor: count ticks across each busy period and score it when busy drops.
  logic tk;
  logic prev_busy = 1'b0;
  int   tick_cnt = 0;
  always begin
    @(posedge clk);
    tk = rx_enb;
    #1;
    if (!rst) begin
      prev_busy = 1'b0;
      tick_cnt  = 0;
    end else begin
      if (busy && !prev_busy) tick_cnt = 0;
      else if (prev_busy && tk) tick_cnt++;
      if (prev_busy && !busy) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame_end: got busy fall after %0d ticks, expected none", tick_cnt);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("frame_ticks", 32'(tick_cnt), 32'(e.ticks));
          check("frame_rdy", 32'(rdy), 32'(e.rdy));
          check("frame_data", 32'(data), 32'(e.data));
          check("frame_frame_err", 32'(frame_err), 32'(e.fe));
          check("frame_overrun", 32'(overrun), 32'(e.ov));
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t g;
    rst     = 1'b0;
    rx      = 1'b1;
    rx_enb  = 1'b0;
    rdy_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(data), 32'h00);
    check("reset_rdy", 32'(rdy), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    ticks(4);

    // Good byte
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    clr_pulse();

    // Start glitch: three low ticks then high
    g.ticks = 8;
    g.rdy   = m_rdy;
    g.data  = m_data;
    g.fe    = m_fe;
    g.ov    = m_ov;
    q.push_back(g);
    rx = 1'b0;
    ticks(3);
    rx = 1'b1;
    ticks(20);

    // Framing error, then clear
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    ticks(4);
    clr_pulse();

    // Overrun, then clear; repeat with clear on the completion clock
    send_frame(8'h11, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    clr_pulse();
    send_frame(8'h11, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b1, -1);
    clr_pulse();

    // Reset mid-frame after four data bits of 0xFF
    rx = 1'b0;
    ticks(OS);
    rx = 1'b1;
    ticks(4 * OS);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_data", 32'(data), 32'h00);
    check("midrst_rdy", 32'(rdy), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    m_rdy  = 1'b0;
    m_data = 8'h00;
    m_fe   = 1'b0;
    m_ov   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ticks(4);
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    clr_pulse();

    // Tick stall mid data bit
    send_frame(8'hC3, 1'b1, 1'b0, 3);
    ticks(4);

    for (int i = 0; i < 1000 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver.
- Sits directly downstream of the baud rate generator and consumes its 16x-oversample `rx_enb` tick (one pulse per 325 clk at 50 MHz/9600 baud).
- Synchronises the asynchronous serial line, detects and validates the start bit, centre-samples each data bit, checks the stop bit, and presents the received byte with a ready flag to the consuming logic.
- All state advances are gated by `rx_enb`.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first.
- OVERSAMPLE, 16, `rx_enb` ticks per bit period; must be even and at least 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset: asserted when 0, released synchronously to clk.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_enb  input  1  oversample tick from the baud generator, one clk wide.
- rdy_clr  input  1  consumer acknowledge; clears rdy, frame_err and overrun.
- data  output  DATA_BITS  last good received byte.
- rdy  output  1  byte available.
- frame_err  output  1  sticky; set when a stop bit is sampled low.
- overrun  output  1  sticky; set when a good byte completes while rdy=1 and rdy_clr=0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous), all registers forced as follows:
  - state=IDLE, sample_cnt=0, bit_idx=0, shift register=0.
  - Both synchroniser flops = 1.
  - data=0, rdy=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame abandons the frame with no output update.
- Synchroniser: rx passes through 2 flops every clk, independent of rx_enb. rx_s is the second flop. All decisions use rx_s only.
- When rx_enb=0, state, sample_cnt, bit_idx and the shift register hold. rdy_clr is honoured on any clk.
- IDLE: on a tick with rx_s=0, go to START with sample_cnt=0.
- START: on each tick:
  - If sample_cnt == OVERSAMPLE/2-1, evaluate rx_s:
    - rx_s=0: go to DATA, sample_cnt=0, bit_idx=0.
    - rx_s=1: glitch; go to IDLE with no flag.
  - Otherwise sample_cnt++.
  - Net effect: the start bit is evaluated on the 8th tick after the detection tick.
- DATA: on each tick:
  - If sample_cnt == OVERSAMPLE-1: shift register <= {rx_s, shift[DATA_BITS-1:1]} (LSB first) and sample_cnt=0. If bit_idx == DATA_BITS-1, go to STOP; otherwise bit_idx++.
  - Otherwise sample_cnt++.
- STOP: on the tick with sample_cnt == OVERSAMPLE-1:
  - rx_s=1: data <= shift register, rdy <= 1. overrun <= 1 if rdy was already 1 and rdy_clr=0 on that clk.
  - rx_s=0: frame_err <= 1; data and rdy are unchanged.
  - In both cases go to IDLE and reset sample_cnt.
  - Returning at mid-stop allows a following start bit to be detected with no lost ticks.
- Latency: a good byte's rdy rises on the clk edge of the 152nd tick after the detection tick (8 + 16·8 + 16 with defaults).
- rdy_clr=1: rdy, frame_err and overrun go to 0 on the next edge.
  - If a good byte completes on the same clk: rdy=1, data updated, overrun not set.
  - If a frame error occurs on the same clk: frame_err=1.
- overrun: the new byte overwrites data.
- busy is registered and follows state.
- No break or parity handling.
- Counters never wrap: sample_cnt is bounded by OVERSAMPLE-1 and bit_idx by DATA_BITS-1.

Test Plan:
- Good byte: drive 0xA5 8N1 with exactly 16 ticks per bit, `rx_enb` every 325 clk -> 152 ticks after detection rdy=1, data=0xA5, frame_err=0, overrun=0, busy falls on the same edge.
- Start glitch: rx low for 3 ticks, then high -> busy high for 8 ticks, then IDLE; rdy=0, frame_err=0, data unchanged.
- Framing error: 0x3C with the stop bit driven low -> frame_err=1, rdy=0, data keeps its previous value. rdy_clr pulse -> frame_err=0 next clk.
- Overrun and clear: send 0x11 then 0x22 back-to-back without rdy_clr -> data=0x22, rdy=1, overrun=1. rdy_clr -> rdy=0, overrun=0. Repeat with rdy_clr coincident with the 0x22 completion -> rdy=1, overrun=0.
- Reset mid-frame: assert rst=0 after 4 data bits of 0xFF, asynchronously between clk edges -> all outputs are 0 immediately. Release, then send 0x5A -> data=0x5A, rdy=1.
- Tick stall: hold rx_enb=0 for 1000 clk mid-data-bit while rx holds its level -> no state change. Resume ticks -> byte 0xC3 received correctly.
